// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin output multiplexer.
// Holds the select-width helper and the packet hold-state enum. The enum
// is only used when MUX_RR_ARB_PKT_LOCK_EN is defined.
package mux_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } hold_state_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int sel_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant and pointer logic.
// The grant goes to the first requesting channel at or above ptr, wrapping
// from N-1 to 0. ptr moves to one past the grant when advance is asserted.
import mux_pkg::*;

module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = sel_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant_oh,
    output logic [SEL_W-1:0] grant_idx,
    output logic [SEL_W-1:0] ptr
);

    localparam logic [SEL_W:0] N_EXT   = (SEL_W+1)'(N);
    localparam logic [SEL_W:0] ONE_EXT = (SEL_W+1)'(1);

    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W:0]   ptr_ext_s;
    logic [2*N-1:0]   req2_s;
    logic [N-1:0]     rot_s;
    logic             found_s;
    logic [SEL_W-1:0] pos_s;
    logic [SEL_W:0]   sum_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic [N-1:0]     grant_oh_s;
    logic [SEL_W:0]   inc_s;
    logic [SEL_W-1:0] ptr_nxt_s;

    // Rotate requests so ptr sits at bit 0, pick the lowest set bit, then un-rotate.
    always_comb begin
        ptr_ext_s = {1'b0, ptr_r};
        req2_s    = {req, req};
        rot_s     = req2_s[ptr_ext_s +: N];
        found_s   = 1'b0;
        pos_s     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                found_s = 1'b1;
                pos_s   = SEL_W'(i);
            end else begin
                found_s = found_s;
            end
        end
        sum_s = ptr_ext_s + {1'b0, pos_s};
        if (sum_s >= N_EXT) begin
            grant_idx_s = SEL_W'(sum_s - N_EXT);
        end else begin
            grant_idx_s = SEL_W'(sum_s);
        end
        for (int i = 0; i < N; i++) begin
            grant_oh_s[i] = found_s && (grant_idx_s == SEL_W'(i));
        end
    end

    // Next pointer is one past the current grant, wrapping at N.
    always_comb begin
        inc_s = {1'b0, grant_idx_s} + ONE_EXT;
        if (inc_s >= N_EXT) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = SEL_W'(inc_s);
        end
    end

    // Pointer register: cleared by reset, moved only on an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign grant_oh  = grant_oh_s;
    assign grant_idx = grant_idx_s;
    assign ptr       = ptr_r;

endmodule

// File: rtl/mux_rr_arb.sv
// N-to-1 round-robin multiplexer with a one-beat registered output stage.
// Optional packet locking is enabled by defining MUX_RR_ARB_PKT_LOCK_EN. When
// it is enabled, a channel keeps the grant until it delivers a beat with
// in_last set.
import mux_pkg::*;

module mux_rr_arb #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SEL_W = sel_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
`ifdef MUX_RR_ARB_PKT_LOCK_EN
    input  logic [N-1:0]     in_last,
    output logic             out_last,
`endif
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
);

    logic             out_valid_r;
    logic [W-1:0]     out_data_r;
    logic [SEL_W-1:0] out_sel_r;
    logic             load_s;
    logic [N-1:0]     req_s;
    logic [N-1:0]     grant_oh_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic [SEL_W-1:0] ptr_s;
    logic             any_grant_s;
    logic             accept_s;
    logic             advance_s;
    logic [W-1:0]     sel_data_s;
    logic [N-1:0]     in_ready_s;

    // The output register can take a new beat when it is empty or draining.
    assign load_s      = !out_valid_r || out_ready;
    assign any_grant_s = |grant_oh_s;
    assign accept_s    = !rst && load_s && any_grant_s;

`ifdef MUX_RR_ARB_PKT_LOCK_EN
    hold_state_e      state_r, state_nxt_s;
    logic [SEL_W-1:0] lock_idx_r, lock_idx_nxt_s;
    logic [N-1:0]     lock_mask_s;
    logic             last_sel_s;
    logic             out_last_r;

    // While a packet is open, only the locked channel may request.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lock_mask_s[i] = (lock_idx_r == SEL_W'(i));
        end
        if (state_r == LOCKED) begin
            req_s = in_valid & lock_mask_s;
        end else begin
            req_s = in_valid;
        end
        last_sel_s = |(in_last & grant_oh_s);
        advance_s  = accept_s && last_sel_s;
    end

    // Packet hold next state: open on a non-last beat, close on a last beat.
    always_comb begin
        state_nxt_s    = state_r;
        lock_idx_nxt_s = lock_idx_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !last_sel_s) begin
                    state_nxt_s    = LOCKED;
                    lock_idx_nxt_s = grant_idx_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (accept_s && last_sel_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Packet hold state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            lock_idx_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            lock_idx_r <= lock_idx_nxt_s;
        end
    end

    // out_last travels with the data it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_last_r <= 1'b0;
        end else if (accept_s) begin
            out_last_r <= last_sel_s;
        end
    end

    assign out_last = out_last_r;
`else
    assign req_s     = in_valid;
    assign advance_s = accept_s;
`endif

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_s),
        .advance   (advance_s),
        .grant_oh  (grant_oh_s),
        .grant_idx (grant_idx_s),
        .ptr       (ptr_s)
    );

    // AND-OR select so that ungranted channels can never reach the output.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_oh_s[i]) begin
                sel_data_s = sel_data_s | in_data[i*W +: W];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Accept only the granted channel, and nothing during reset or backpressure.
    always_comb begin
        if (rst || !load_s) begin
            in_ready_s = '0;
        end else begin
            in_ready_s = grant_oh_s;
        end
    end

    // Output register: load a new beat, or empty out when there is nothing to send.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sel_r   <= '0;
        end else if (load_s) begin
            out_valid_r <= any_grant_s;
            if (any_grant_s) begin
                out_data_r <= sel_data_s;
                out_sel_r  <= grant_idx_s;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed self-checking bench for mux_rr_arb (N=4, W=8).
// The packet-lock scenario is included when MUX_RR_ARB_PKT_LOCK_EN is defined.
module tb_mux_rr_arb;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;
`ifdef MUX_RR_ARB_PKT_LOCK_EN
    logic [N-1:0]     in_last;
    logic             out_last;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_rr_arb #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef MUX_RR_ARB_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready = 1'b1;
`ifdef MUX_RR_ARB_PKT_LOCK_EN
        in_last   = 4'h0;
`endif
        step();
        step();
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL reset_in_ready got %h exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got %0d exp 0", out_sel); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rdy;
        logic [SEL_W-1:0] exp_sel;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_sel = SEL_W'(k % N);
            exp_rdy = 4'b0001 << exp_sel;
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rr_in_ready beat %0d got %b exp %b", k, in_ready, exp_rdy); end
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_out_valid beat %0d got %b exp 1", k, out_valid); end
            checks++; if (out_sel !== exp_sel) begin errors++; $display("FAIL rr_out_sel beat %0d got %0d exp %0d", k, out_sel, exp_sel); end
            checks++; if (out_data !== (8'hA0 + 8'(exp_sel))) begin errors++; $display("FAIL rr_out_data beat %0d got %h exp %h", k, out_data, 8'hA0 + 8'(exp_sel)); end
        end
    endtask

    task automatic test_backpressure();
        // ptr is 1: take channel 1 then channel 2
        step();
        step();
        checks++; if (out_sel !== 2'd2 || out_data !== 8'hA2) begin errors++; $display("FAIL bp_setup got sel %0d data %h exp 2 A2", out_sel, out_data); end
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b exp 0000", k, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'hA2) begin errors++; $display("FAIL bp_hold cycle %0d got v%b sel %0d data %h exp v1 2 A2", k, out_valid, out_sel, out_data); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b exp 1000", in_ready); end
        step();
        checks++; if (out_sel !== 2'd3 || out_data !== 8'hA3) begin errors++; $display("FAIL bp_release_beat got sel %0d data %h exp 3 A3", out_sel, out_data); end
    endtask

    task automatic test_sparse_wrap();
        // ptr is 0; junk on ungranted channels must not leak
        in_valid = 4'b0010;
        in_data  = {8'hFF, 8'hFF, 8'hA1, 8'hFF};
        #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL sparse_ready1 got %b exp 0010", in_ready); end
        step();
        checks++; if (out_sel !== 2'd1 || out_data !== 8'hA1) begin errors++; $display("FAIL sparse_beat1 got sel %0d data %h exp 1 A1", out_sel, out_data); end
        // ptr is now 2; only channel 1 requests, so the search wraps
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ready got %b exp 0010", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'hA1) begin errors++; $display("FAIL wrap_beat got v%b sel %0d data %h exp v1 1 A1", out_valid, out_sel, out_data); end
        in_valid = 4'hF;
        in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ptr_after got %b exp 0100", in_ready); end
        step();
        checks++; if (out_sel !== 2'd2 || out_data !== 8'hA2) begin errors++; $display("FAIL wrap_next_beat got sel %0d data %h exp 2 A2", out_sel, out_data); end
    endtask

    task automatic test_empty();
        in_valid = 4'h0;
        #1;
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL empty_ready got %b exp 0000", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_valid got %b exp 0", out_valid); end
        checks++; if (out_sel !== 2'd2 || out_data !== 8'hA2) begin errors++; $display("FAIL empty_hold got sel %0d data %h exp 2 A2", out_sel, out_data); end
    endtask

    task automatic test_mid_reset();
        // ptr is 3 here
        in_valid = 4'hF;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL midrst_pre_ready got %b exp 1000", in_ready); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL midrst_ready got %b exp 0000", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin errors++; $display("FAIL midrst_out got v%b sel %0d data %h exp v0 0 00", out_valid, out_sel, out_data); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ptr got %b exp 0001", in_ready); end
        step();
        checks++; if (out_sel !== 2'd0 || out_data !== 8'hA0) begin errors++; $display("FAIL midrst_beat got sel %0d data %h exp 0 A0", out_sel, out_data); end
    endtask

`ifdef MUX_RR_ARB_PKT_LOCK_EN
    task automatic test_pkt_lock();
        // reset first so ptr is 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 4'b0011;
        for (int b = 0; b < 3; b++) begin
            in_last = (b == 2) ? 4'b0001 : 4'b0000;
            #1;
            checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL lock_ready beat %0d got %b exp 0001", b, in_ready); end
            step();
            checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL lock_sel beat %0d got %0d exp 0", b, out_sel); end
        end
        in_last = 4'b0010;
        #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL lock_after_ready got %b exp 0010", in_ready); end
        step();
        checks++; if (out_sel !== 2'd1 || out_last !== 1'b1) begin errors++; $display("FAIL lock_after_sel got %0d last %b exp 1 1", out_sel, out_last); end
        // open a packet on channel 0 (ptr is 2, search wraps to 0), then reset
        in_last = 4'b0000;
        step();
        checks++; if (out_sel !== 2'd0 || out_last !== 1'b0) begin errors++; $display("FAIL lock_open got %0d last %b exp 0 0", out_sel, out_last); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 4'b0010;
        #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL lock_rst_idle got %b exp 0010", in_ready); end
        step();
        checks++; if (out_sel !== 2'd1) begin errors++; $display("FAIL lock_rst_beat got %0d exp 1", out_sel); end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_sparse_wrap();
        test_empty();
        test_mid_reset();
`ifdef MUX_RR_ARB_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_arb.md
MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 SHALL have parameter N, default 4: number of input channels, range 2..16.
REQ-002 SHALL have parameter W, default 8: data width per channel, range 1..64.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, N bits: per-channel data valid.
REQ-006 SHALL have port in_data, input, N*W bits: channel i occupies bits [i*W +: W].
REQ-007 SHALL have port in_ready, output, N bits: per-channel accept.
REQ-008 SHALL have port out_valid, output, 1 bit: output register holds a beat.
REQ-009 SHALL have port out_data, output, W bits: registered selected data.
REQ-010 SHALL have port out_sel, output, SEL_W bits: source channel of out_data; SEL_W = max(1, clog2(N)).
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-012 SHALL transfer on a channel when its in_valid and in_ready are both 1 at a rising edge; it SHALL transfer on the output when out_valid and out_ready are both 1.
REQ-013 SHALL compute load = !out_valid || out_ready; in_ready SHALL be one-hot or zero, with in_ready[g] = load && in_valid[g] for granted channel g.
REQ-014 SHALL perform round-robin grant: the requesting channel closest to ptr, searching upward from ptr with wrap N-1 -> 0, is granted; the grant is combinational in the same cycle.
REQ-015 SHALL update ptr to (g+1) mod N after an accepted input beat; ptr SHALL be unchanged when no beat is accepted.
REQ-016 SHALL register in_data[g], with out_sel = g and out_valid = 1, on the accepting edge; input-to-output latency is 1 cycle.
REQ-017 SHALL, when load is 1 and no channel is valid, clear out_valid on that edge; out_data and out_sel SHALL then hold their old values.
REQ-018 SHALL, while out_valid=1 and out_ready=0, hold out_data and out_sel stable and drive in_ready = 0.
REQ-019 SHALL sustain full throughput: with out_ready held at 1, one beat per cycle.
REQ-020 SHALL give every channel with continuous in_valid a grant within N accepted beats; no starvation.
REQ-021 SHALL NOT let in_data of ungranted channels affect any output.

Reset
REQ-022 SHALL, with rst=1 at an edge, set out_valid=0, out_data=0, out_sel=0, ptr=0 and the hold state to IDLE; rst SHALL take precedence over every transfer.
REQ-023 SHALL drive in_ready=0 combinationally while rst=1; a beat in flight at reset is discarded.

Configuration
REQ-024 SHALL provide macro MUX_RR_ARB_PKT_LOCK_EN.
- Defined: adds input in_last (N bits) and output out_last (1 bit, registered with data).
- Defined: adds states IDLE -> LOCKED on an accepted beat with in_last[g]=0, and LOCKED -> IDLE on an accepted beat with in_last[g]=1.
- Defined: in LOCKED, the grant is fixed to the locked channel and ptr is frozen.
- Defined: ptr advances to (g+1) mod N only on the last beat of a packet.
- Not defined: no in_last or out_last ports, no LOCKED state; arbitration happens every beat per REQ-014/015.

Structure
REQ-025 SHALL place the sel_w(N) function and the state enum {IDLE, LOCKED} in shared package mux_pkg.
REQ-026 SHALL implement the grant and pointer logic in sub-module rr_arbiter with ports clk, rst, req[N], advance, grant_oh[N], grant_idx[SEL_W] and ptr state; mux_rr_arb SHALL instantiate it once.

Verification
REQ-027 Reset: rst=1 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
REQ-028 Round-robin: N=4, W=8, all in_valid=1, data i = 8'hA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0 with data A0,A1,A2,A3,A0 and one beat per cycle.
REQ-029 Backpressure: out_ready=0 for 3 cycles after a beat from channel 2 -> out_data and out_sel stable, in_ready=0; on release the next grant is channel 3.
REQ-030 Sparse/wrap: only channel 1 valid, ptr=2 -> channel 1 granted via wrap; ptr becomes 2 afterwards.
REQ-031 Empty: no in_valid with out_ready=1 -> out_valid=0 one cycle after the last beat.
REQ-032 With MUX_RR_ARB_PKT_LOCK_EN: channel 0 sends a 3-beat packet (in_last on beat 3) while channel 1 is valid -> outputs 0,0,0 then 1; mid-packet rst returns the block to IDLE with ptr=0.
